// File: rtl/mul_sched.sv
// mul_sched: round-robin 2-client front end and sequencer for the
// repeated-addition multiplier datapath (A reg, P accumulator, B down-counter).
module mul_sched #(
  parameter int unsigned WIDTH    = 16,
  parameter int unsigned MAX_ITER = 65535
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [1:0]       req,
  input  logic [WIDTH-1:0] op_a0,
  input  logic [WIDTH-1:0] op_b0,
  input  logic [WIDTH-1:0] op_a1,
  input  logic [WIDTH-1:0] op_b1,
  output logic [1:0]       gnt,
  output logic             busy,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_id,
  output logic [WIDTH-1:0] rsp_data,
  output logic             rsp_err,
  output logic [WIDTH-1:0] dp_bus,
  output logic             dp_ldA,
  output logic             dp_ldB,
  output logic             dp_ldP,
  output logic             dp_clrP,
  output logic             dp_decB,
  input  logic             dp_eqz,
  input  logic [WIDTH-1:0] dp_prod
);

  localparam int unsigned IW = (MAX_ITER < 2) ? 1 : $clog2(MAX_ITER + 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LOAD_A = 3'd1,
    S_LOAD_B = 3'd2,
    S_RUN    = 3'd3,
    S_CAPT   = 3'd4,
    S_RESP   = 3'd5
  } state_t;

  state_t            state;
  logic              prio;
  logic              owner;
  logic              err;
  logic [WIDTH-1:0]  op_a;
  logic [WIDTH-1:0]  op_b;
  logic [WIDTH-1:0]  result;
  logic [IW-1:0]     iter;

  logic              any_req;
  logic              win;
  logic              run_step;

  // Arbitration: priority client wins if requesting, otherwise the other one.
  always_comb begin
    any_req = |req;
    win     = prio;
    if (!req[prio]) begin
      win = ~prio;
    end
  end

  // Grant is a same-cycle pulse in IDLE so the operands sampled at this edge belong to it.
  assign gnt = (state == S_IDLE && rst_n && any_req) ? (win ? 2'b10 : 2'b01) : 2'b00;

  // One add/decrement per RUN cycle until the counter hits zero or the watchdog trips.
  assign run_step = (state == S_RUN) && !dp_eqz && (iter != IW'(MAX_ITER));
  assign dp_ldP   = run_step;
  assign dp_decB  = run_step;

  // Moore-decoded datapath strobes and status.
  assign dp_ldA    = (state == S_LOAD_A);
  assign dp_ldB    = (state == S_LOAD_B);
  assign dp_clrP   = (state == S_LOAD_B);
  assign busy      = (state != S_IDLE);
  assign rsp_valid = (state == S_RESP);
  assign rsp_id    = owner;
  assign rsp_data  = result;
  assign rsp_err   = err;

  // Shared bus carries the latched operand only while it is being loaded.
  always_comb begin
    dp_bus = '0;
    case (state)
      S_LOAD_A: dp_bus = op_a;
      S_LOAD_B: dp_bus = op_b;
      default:  dp_bus = '0;
    endcase
  end

  // Sequencer state, operand/result capture and round-robin pointer.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= S_IDLE;
      prio   <= 1'b0;
      owner  <= 1'b0;
      err    <= 1'b0;
      op_a   <= '0;
      op_b   <= '0;
      result <= '0;
      iter   <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (any_req) begin
            op_a  <= win ? op_a1 : op_a0;
            op_b  <= win ? op_b1 : op_b0;
            owner <= win;
            err   <= 1'b0;
            state <= S_LOAD_A;
          end
        end
        S_LOAD_A: begin
          state <= S_LOAD_B;
        end
        S_LOAD_B: begin
          iter  <= '0;
          state <= S_RUN;
        end
        S_RUN: begin
          if (dp_eqz) begin
            state <= S_CAPT;
          end else if (iter == IW'(MAX_ITER)) begin
            err   <= 1'b1;
            state <= S_CAPT;
          end else begin
            iter <= iter + IW'(1);
          end
        end
        S_CAPT: begin
          result <= err ? '0 : dp_prod;
          state  <= S_RESP;
        end
        S_RESP: begin
          if (rsp_ready) begin
            prio  <= ~owner;
            state <= S_IDLE;
          end
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mul_sched.sv
// tb_mul_sched: directed vectors and corner sequences for mul_sched, with a
// behavioural datapath model closing the loop on the main instance.
module tb_mul_sched;

  logic        clk;
  logic        rst_n;
  logic [1:0]  req;
  logic [15:0] op_a0, op_b0, op_a1, op_b1;
  logic [1:0]  gnt;
  logic        busy, rsp_valid, rsp_ready, rsp_id, rsp_err;
  logic [15:0] rsp_data, dp_bus;
  logic        dp_ldA, dp_ldB, dp_ldP, dp_clrP, dp_decB, dp_eqz;
  logic [15:0] dp_prod;

  // watchdog instance: eqz stuck low, accumulator showing a nonzero value
  logic [1:0]  req1;
  logic [1:0]  gnt1;
  logic        busy1, rsp_valid1, rsp_id1, rsp_err1;
  logic [15:0] rsp_data1, dp_bus1;
  logic        ldA1, ldB1, ldP1, clrP1, decB1;

  int checks = 0;
  int failures = 0;
  int ldp_total = 0;
  int decb_total = 0;
  int ldp1_total = 0;
  int decb1_total = 0;

  logic [15:0] m_a = '0;
  logic [15:0] m_b = '0;
  logic [15:0] m_p = '0;

  mul_sched #(.WIDTH(16), .MAX_ITER(65535)) u_dut (
    .clk(clk), .rst_n(rst_n), .req(req),
    .op_a0(op_a0), .op_b0(op_b0), .op_a1(op_a1), .op_b1(op_b1),
    .gnt(gnt), .busy(busy), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_id(rsp_id), .rsp_data(rsp_data), .rsp_err(rsp_err),
    .dp_bus(dp_bus), .dp_ldA(dp_ldA), .dp_ldB(dp_ldB), .dp_ldP(dp_ldP),
    .dp_clrP(dp_clrP), .dp_decB(dp_decB), .dp_eqz(dp_eqz), .dp_prod(dp_prod)
  );

  mul_sched #(.WIDTH(16), .MAX_ITER(4)) u_wd (
    .clk(clk), .rst_n(rst_n), .req(req1),
    .op_a0(16'd9), .op_b0(16'd7), .op_a1(16'd0), .op_b1(16'd0),
    .gnt(gnt1), .busy(busy1), .rsp_valid(rsp_valid1), .rsp_ready(1'b1),
    .rsp_id(rsp_id1), .rsp_data(rsp_data1), .rsp_err(rsp_err1),
    .dp_bus(dp_bus1), .dp_ldA(ldA1), .dp_ldB(ldB1), .dp_ldP(ldP1),
    .dp_clrP(clrP1), .dp_decB(decB1), .dp_eqz(1'b0), .dp_prod(16'h5555)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // datapath model: A register, P accumulator, B down-counter
  always @(posedge clk) begin
    if (dp_ldA) m_a <= dp_bus;
    if (dp_ldB) m_b <= dp_bus;
    else if (dp_decB) m_b <= m_b - 16'd1;
    if (dp_clrP) m_p <= 16'd0;
    else if (dp_ldP) m_p <= m_p + m_a;
  end
  assign dp_eqz  = (m_b == 16'd0);
  assign dp_prod = m_p;

  // strobe pulse counters
  always @(negedge clk) begin
    if (dp_ldP) ldp_total <= ldp_total + 1;
    if (dp_decB) decb_total <= decb_total + 1;
    if (ldP1) ldp1_total <= ldp1_total + 1;
    if (decB1) decb1_total <= decb1_total + 1;
  end

  typedef struct {
    logic        cl;
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] exp_data;
    int          exp_lat;
    int          exp_adds;
  } vec_t;

  vec_t vecs [6];

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic wait_gnt(input logic [1:0] exp, input string nm);
    int n = 0;
    #1;
    while (gnt == 2'b00 && n < 40) begin
      step();
      #1;
      n++;
    end
    check(nm, 32'(gnt), 32'(exp));
  endtask

  // called one clock after the grant cycle; stops in the first rsp_valid cycle
  task automatic wait_rsp(input logic exp_id, input logic [15:0] exp_data,
                          input int exp_lat, input string nm);
    int lat = 1;
    while (!rsp_valid && lat < 400) begin
      step();
      lat++;
    end
    check({nm, "_lat"}, 32'(lat), 32'(exp_lat));
    check({nm, "_valid"}, 32'(rsp_valid), 32'd1);
    check({nm, "_id"}, 32'(rsp_id), 32'(exp_id));
    check({nm, "_data"}, 32'(rsp_data), 32'(exp_data));
    check({nm, "_err"}, 32'(rsp_err), 32'd0);
  endtask

  task automatic run_vec(input vec_t v, input string nm);
    int l0;
    int d0;
    req = 2'b00;
    if (v.cl) begin op_a1 = v.a; op_b1 = v.b; end
    else      begin op_a0 = v.a; op_b0 = v.b; end
    req[v.cl] = 1'b1;
    wait_gnt(v.cl ? 2'b10 : 2'b01, {nm, "_gnt"});
    l0 = ldp_total;
    d0 = decb_total;
    step();
    req = 2'b00;
    wait_rsp(v.cl, v.exp_data, v.exp_lat, nm);
    check({nm, "_adds"}, 32'(ldp_total - l0), 32'(v.exp_adds));
    check({nm, "_decs"}, 32'(decb_total - d0), 32'(v.exp_adds));
    step();
  endtask

  initial begin
    int bad;
    int n;
    int lat;
    int l0;
    int d0;

    vecs[0] = '{cl: 1'b0, a: 16'd7,     b: 16'd5,   exp_data: 16'd35,    exp_lat: 10,  exp_adds: 5};
    vecs[1] = '{cl: 1'b1, a: 16'd1234,  b: 16'd0,   exp_data: 16'd0,     exp_lat: 5,   exp_adds: 0};
    vecs[2] = '{cl: 1'b0, a: 16'h8000,  b: 16'd3,   exp_data: 16'h8000,  exp_lat: 8,   exp_adds: 3};
    vecs[3] = '{cl: 1'b1, a: 16'd0,     b: 16'd4,   exp_data: 16'd0,     exp_lat: 9,   exp_adds: 4};
    vecs[4] = '{cl: 1'b0, a: 16'd300,   b: 16'd300, exp_data: 16'd24464, exp_lat: 305, exp_adds: 300};
    vecs[5] = '{cl: 1'b1, a: 16'hFFFF,  b: 16'd2,   exp_data: 16'hFFFE,  exp_lat: 7,   exp_adds: 2};

    rst_n = 1'b0;
    req = 2'b00;
    req1 = 2'b00;
    rsp_ready = 1'b1;
    op_a0 = '0; op_b0 = '0; op_a1 = '0; op_b1 = '0;
    repeat (3) step();
    rst_n = 1'b1;
    step();

    // reset state
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_gnt", 32'(gnt), 32'd0);
    check("rst_rsp", 32'({rsp_valid, rsp_id, rsp_err}), 32'd0);
    check("rst_data", 32'(rsp_data), 32'd0);
    check("rst_strobes", 32'({dp_ldA, dp_ldB, dp_ldP, dp_clrP, dp_decB}), 32'd0);
    check("rst_bus", 32'(dp_bus), 32'd0);
    check("rst_wd", 32'({busy1, ldA1, ldB1, clrP1, ldP1, decB1, rsp_id1, gnt1}), 32'd0);
    check("rst_wd_bus", 32'(dp_bus1), 32'd0);

    // simultaneous requests: client 0 first, then client 1, then client 0 again
    op_a0 = 16'd3; op_b0 = 16'd4; op_a1 = 16'd6; op_b1 = 16'd2;
    req = 2'b11;
    wait_gnt(2'b01, "rr1_gnt");
    step();
    req = 2'b10;
    wait_rsp(1'b0, 16'd12, 9, "rr1");
    step();
    wait_gnt(2'b10, "rr2_gnt");
    step();
    req = 2'b00;
    wait_rsp(1'b1, 16'd12, 7, "rr2");
    step();
    req = 2'b11;
    wait_gnt(2'b01, "rr3_gnt");
    step();
    req = 2'b00;
    wait_rsp(1'b0, 16'd12, 9, "rr3");
    step();
    #1;
    check("withdrawn_no_gnt", 32'(gnt), 32'd0);

    // consumer stalls with both clients pending; priority now at client 1
    rsp_ready = 1'b0;
    op_a0 = 16'd5; op_b0 = 16'd2; op_a1 = 16'd9; op_b1 = 16'd3;
    req = 2'b11;
    wait_gnt(2'b10, "stall_gnt");
    step();
    req = 2'b01;
    wait_rsp(1'b1, 16'd27, 8, "stall");
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      #1;
      if (!rsp_valid || rsp_data != 16'd27 || rsp_id != 1'b1 || gnt != 2'b00) bad++;
    end
    check("stall_hold", 32'(bad), 32'd0);
    rsp_ready = 1'b1;
    step();
    #1;
    check("stall_next_gnt", 32'(gnt), 32'b01);
    step();
    req = 2'b00;
    wait_rsp(1'b0, 16'd10, 7, "after_stall");
    step();

    // table of single-client operations
    for (int i = 0; i < 6; i++) begin
      run_vec(vecs[i], $sformatf("vec%0d", i));
    end

    // reset in the middle of RUN
    op_a0 = 16'd10; op_b0 = 16'd50;
    req = 2'b01;
    wait_gnt(2'b01, "mid_gnt");
    step();
    req = 2'b00;
    repeat (4) step();
    check("mid_in_run", 32'(dp_ldP), 32'd1);
    rst_n = 1'b0;
    step();
    #1;
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_out", 32'({gnt, rsp_valid, rsp_id, rsp_err, dp_ldA, dp_ldB, dp_ldP, dp_clrP, dp_decB}), 32'd0);
    check("mid_rst_bus", 32'(dp_bus | rsp_data), 32'd0);
    rst_n = 1'b1;
    bad = 0;
    for (int i = 0; i < 60; i++) begin
      step();
      if (rsp_valid || busy) bad++;
    end
    check("mid_no_rsp", 32'(bad), 32'd0);
    run_vec('{cl: 1'b1, a: 16'd11, b: 16'd3, exp_data: 16'd33, exp_lat: 8, exp_adds: 3}, "post_rst");

    // watchdog: counter never reaches zero, limit of 4 iterations
    req1 = 2'b01;
    n = 0;
    #1;
    while (gnt1 == 2'b00 && n < 40) begin
      step();
      #1;
      n++;
    end
    check("wd_gnt", 32'(gnt1), 32'b01);
    l0 = ldp1_total;
    d0 = decb1_total;
    step();
    req1 = 2'b00;
    lat = 1;
    while (!rsp_valid1 && lat < 100) begin
      step();
      lat++;
    end
    check("wd_lat", 32'(lat), 32'd9);
    check("wd_valid", 32'(rsp_valid1), 32'd1);
    check("wd_err", 32'(rsp_err1), 32'd1);
    check("wd_data", 32'(rsp_data1), 32'd0);
    check("wd_adds", 32'(ldp1_total - l0), 32'd4);
    check("wd_decs", 32'(decb1_total - d0), 32'd4);
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
